// File: rtl/cpu_mult_shift_pkg.sv
// Shared operation encodings for the two-stage multiply/shift unit.
package cpu_mult_shift_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_MUL_LO = 3'd0,
      MODE_MUL_HI = 3'd1,
      MODE_SHL    = 3'd2,
      MODE_SHR_L  = 3'd3,
      MODE_SHR_A  = 3'd4,
      MODE_ROL    = 3'd5,
      MODE_ROR    = 3'd6,
      MODE_ZERO   = 3'd7
   } mode_e;

endpackage

// File: rtl/cpu_mult_shift_datapath.sv
// Combinational result generator: multiply (low/high half) and shift/rotate.
module cpu_mult_shift_datapath
   import cpu_mult_shift_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] src1_i,
   input  logic [DATA_W-1:0] src2_i,
   input  mode_e             mode_i,
   input  logic              src1_signed_i,
   input  logic              src2_signed_i,
   output logic [DATA_W-1:0] result_o
);

   localparam int SHAMT_W = $clog2(DATA_W);

   logic [2*DATA_W-1:0] ext1, ext2, prod;
   logic [SHAMT_W-1:0]  shamt;
   logic [DATA_W-1:0]   rol_res, ror_res;

   always_comb begin
      shamt = src2_i[SHAMT_W-1:0];
      // Low 2*DATA_W bits of the extended product equal the true signed/unsigned product.
      ext1  = {{DATA_W{src1_signed_i & src1_i[DATA_W-1]}}, src1_i};
      ext2  = {{DATA_W{src2_signed_i & src2_i[DATA_W-1]}}, src2_i};
      prod  = ext1 * ext2;
   end

   // Index arithmetic wraps at SHAMT_W bits, giving modulo-DATA_W rotation.
   always_comb begin
      rol_res = '0;
      ror_res = '0;
      for (int i = 0; i < DATA_W; i++) begin
         ror_res[i] = src1_i[SHAMT_W'(i) + shamt];
         rol_res[i] = src1_i[SHAMT_W'(i) - shamt];
      end
   end

   always_comb begin
      result_o = '0;
      case (mode_i)
         MODE_MUL_LO: result_o = prod[DATA_W-1:0];
         MODE_MUL_HI: result_o = prod[2*DATA_W-1:DATA_W];
         MODE_SHL:    result_o = src1_i << shamt;
         MODE_SHR_L:  result_o = src1_i >> shamt;
         MODE_SHR_A:  result_o = DATA_W'($signed(src1_i) >>> shamt);
         MODE_ROL:    result_o = rol_res;
         MODE_ROR:    result_o = ror_res;
         default:     result_o = '0;
      endcase
   end

endmodule

// File: rtl/cpu_mult_shift_unit.sv
// Two-stage multiply/shift unit: stage 1 latches operands on M_en, stage 2
// registers the computed result on A_en.
module cpu_mult_shift_unit
   import cpu_mult_shift_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              E_valid,
   input  logic [DATA_W-1:0] E_src1,
   input  logic [DATA_W-1:0] E_src2,
   input  logic [MODE_W-1:0] E_mode,
   input  logic              E_src1_signed,
   input  logic              E_src2_signed,
   input  logic              M_en,
   input  logic              A_en,
   input  logic              M_flush,
   output logic [DATA_W-1:0] A_result,
   output logic              A_result_valid
);

   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_src1_q, m_src1_d;
   logic [DATA_W-1:0] m_src2_q, m_src2_d;
   mode_e             m_mode_q, m_mode_d;
   logic              m_s1s_q, m_s1s_d;
   logic              m_s2s_q, m_s2s_d;
   logic [DATA_W-1:0] a_result_q, a_result_d;
   logic              a_valid_q, a_valid_d;
   logic [DATA_W-1:0] dp_result;

   cpu_mult_shift_datapath #(.DATA_W(DATA_W)) u_datapath (
      .src1_i        (m_src1_q),
      .src2_i        (m_src2_q),
      .mode_i        (m_mode_q),
      .src1_signed_i (m_s1s_q),
      .src2_signed_i (m_s2s_q),
      .result_o      (dp_result)
   );

   always_comb begin
      m_valid_d  = m_valid_q;
      m_src1_d   = m_src1_q;
      m_src2_d   = m_src2_q;
      m_mode_d   = m_mode_q;
      m_s1s_d    = m_s1s_q;
      m_s2s_d    = m_s2s_q;
      a_result_d = a_result_q;
      a_valid_d  = a_valid_q;
      if (M_en) begin
         m_valid_d = E_valid;
         m_src1_d  = E_src1;
         m_src2_d  = E_src2;
         m_mode_d  = mode_e'(E_mode);
         m_s1s_d   = E_src1_signed;
         m_s2s_d   = E_src2_signed;
      end
      // A flushed instruction still writes its result; only the valid bit is killed.
      if (A_en) begin
         a_result_d = dp_result;
         a_valid_d  = m_valid_q & ~M_flush;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_valid_q  <= 1'b0;
         m_src1_q   <= '0;
         m_src2_q   <= '0;
         m_mode_q   <= MODE_MUL_LO;
         m_s1s_q    <= 1'b0;
         m_s2s_q    <= 1'b0;
         a_result_q <= '0;
         a_valid_q  <= 1'b0;
      end else begin
         m_valid_q  <= m_valid_d;
         m_src1_q   <= m_src1_d;
         m_src2_q   <= m_src2_d;
         m_mode_q   <= m_mode_d;
         m_s1s_q    <= m_s1s_d;
         m_s2s_q    <= m_s2s_d;
         a_result_q <= a_result_d;
         a_valid_q  <= a_valid_d;
      end
   end

   assign A_result       = a_result_q;
   assign A_result_valid = a_valid_q;

endmodule

// File: tb/tb_cpu_mult_shift_unit.sv
// Directed-vector bench for the multiply/shift unit at DATA_W=32 and DATA_W=8.
module tb_cpu_mult_shift_unit;
   import cpu_mult_shift_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        E_valid, E_s1s, E_s2s;
   logic [31:0] E_src1, E_src2;
   logic [2:0]  E_mode;
   logic        M_en, A_en, M_flush;
   logic [31:0] A_result;
   logic        A_valid;

   logic        e8_valid, e8_s1s, e8_s2s;
   logic [7:0]  e8_src1, e8_src2;
   logic [2:0]  e8_mode;
   logic [7:0]  a8_result;
   logic        a8_valid;

   int n_vec = 0;
   int n_err = 0;

   cpu_mult_shift_unit #(.DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .E_valid(E_valid), .E_src1(E_src1), .E_src2(E_src2),
      .E_mode(E_mode), .E_src1_signed(E_s1s), .E_src2_signed(E_s2s), .M_en(M_en), .A_en(A_en),
      .M_flush(M_flush), .A_result(A_result), .A_result_valid(A_valid)
   );

   cpu_mult_shift_unit #(.DATA_W(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .E_valid(e8_valid), .E_src1(e8_src1), .E_src2(e8_src2),
      .E_mode(e8_mode), .E_src1_signed(e8_s1s), .E_src2_signed(e8_s2s), .M_en(M_en), .A_en(A_en),
      .M_flush(M_flush), .A_result(a8_result), .A_result_valid(a8_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  mode;
      logic [31:0] a;
      logic [31:0] b;
      logic        s1;
      logic        s2;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive32(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] b,
                          input logic s1, input logic s2);
      E_valid = 1'b1; E_mode = mode; E_src1 = a; E_src2 = b; E_s1s = s1; E_s2s = s2;
   endtask

   // One instruction through both stages: M_en edge, then A_en edge.
   task automatic run_op(input int i);
      @(negedge clk);
      drive32(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].s1, vecs[i].s2);
      M_en = 1'b1; A_en = 1'b0;
      @(negedge clk);
      M_en = 1'b0; A_en = 1'b1;
      E_valid = 1'b0; E_src1 = 32'hA5A5_A5A5;
      @(negedge clk);
      A_en = 1'b0;
      check($sformatf("vec%0d_result", i), 64'(A_result), 64'(vecs[i].exp));
      check($sformatf("vec%0d_valid", i), 64'(A_valid), 64'd1);
   endtask

   task automatic run8(input string name, input logic [2:0] mode, input logic [7:0] a,
                       input logic [7:0] b, input logic s1, input logic s2, input logic [7:0] exp);
      @(negedge clk);
      e8_valid = 1'b1; e8_mode = mode; e8_src1 = a; e8_src2 = b; e8_s1s = s1; e8_s2s = s2;
      M_en = 1'b1; A_en = 1'b0;
      @(negedge clk);
      M_en = 1'b0; A_en = 1'b1; e8_valid = 1'b0;
      @(negedge clk);
      A_en = 1'b0;
      check({name, "_result"}, 64'(a8_result), 64'(exp));
      check({name, "_valid"}, 64'(a8_valid), 64'd1);
   endtask

   logic [31:0] b2b_exp [4];

   initial begin
      vecs[0]  = '{MODE_MUL_HI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000};
      vecs[1]  = '{MODE_MUL_HI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE};
      vecs[2]  = '{MODE_MUL_HI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF};
      vecs[3]  = '{MODE_MUL_LO, 32'h1234_5678, 32'h0000_0010, 1'b0, 1'b0, 32'h2345_6780};
      vecs[4]  = '{MODE_SHR_A,  32'h8000_0000, 32'd31,        1'b0, 1'b0, 32'hFFFF_FFFF};
      vecs[5]  = '{MODE_SHR_A,  32'h8000_0000, 32'd33,        1'b0, 1'b0, 32'hC000_0000};
      vecs[6]  = '{MODE_ROR,    32'h0000_0001, 32'd1,         1'b0, 1'b0, 32'h8000_0000};
      vecs[7]  = '{MODE_ROL,    32'h8000_0000, 32'd1,         1'b0, 1'b0, 32'h0000_0001};
      vecs[8]  = '{MODE_SHL,    32'h1234_5678, 32'd0,         1'b0, 1'b0, 32'h1234_5678};
      vecs[9]  = '{MODE_SHL,    32'h0000_0001, 32'd4,         1'b0, 1'b0, 32'h0000_0010};
      vecs[10] = '{MODE_SHR_L,  32'h8000_0000, 32'd4,         1'b0, 1'b0, 32'h0800_0000};
      vecs[11] = '{MODE_ZERO,   32'hDEAD_BEEF, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0000};
      vecs[12] = '{MODE_MUL_LO, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1, 32'hFFFF_FFFE};
      vecs[13] = '{MODE_ROL,    32'h1234_5678, 32'd8,         1'b0, 1'b0, 32'h3456_7812};
      vecs[14] = '{MODE_ROR,    32'h1234_5678, 32'd0,         1'b0, 1'b0, 32'h1234_5678};
      vecs[15] = '{MODE_MUL_HI, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h4000_0000};
      vecs[16] = '{MODE_MUL_HI, 32'h8000_0000, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0001};

      // Reset held with enables active: everything stays at zero.
      reset_n = 1'b0; M_en = 1'b1; A_en = 1'b1; M_flush = 1'b0;
      drive32(MODE_MUL_LO, 32'h0000_1234, 32'd5, 1'b0, 1'b0);
      e8_valid = 1'b1; e8_mode = MODE_MUL_LO; e8_src1 = 8'h12; e8_src2 = 8'h05;
      e8_s1s = 1'b0; e8_s2s = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_result", 64'(A_result), 64'd0);
      check("rst_valid", 64'(A_valid), 64'd0);
      check("rst_result8", 64'(a8_result), 64'd0);
      @(negedge clk);
      reset_n = 1'b1; M_en = 1'b0; A_en = 1'b0; E_valid = 1'b0; e8_valid = 1'b0;

      for (int i = 0; i < NV; i++) run_op(i);

      // Stage 1 holds through a 3-cycle M_en stall while E inputs change.
      @(negedge clk);
      drive32(MODE_MUL_LO, 32'd3, 32'd5, 1'b0, 1'b0);
      M_en = 1'b1;
      @(negedge clk);
      M_en = 1'b0;
      drive32(MODE_SHL, 32'd7, 32'd9, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      A_en = 1'b1;
      @(negedge clk);
      A_en = 1'b0;
      check("stall_result", 64'(A_result), 64'd15);
      check("stall_valid", 64'(A_valid), 64'd1);

      // A_en low: result holds while stage 1 takes a new instruction.
      M_en = 1'b1;
      @(negedge clk);
      M_en = 1'b0; E_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("hold_result", 64'(A_result), 64'd15);
      A_en = 1'b1;
      @(negedge clk);
      check("shl_result", 64'(A_result), 64'h0E00);
      @(negedge clk);
      A_en = 1'b0;
      check("reload_result", 64'(A_result), 64'h0E00);
      check("reload_valid", 64'(A_valid), 64'd1);

      // Back-to-back issue: result of op k appears two iterations after it is driven.
      b2b_exp[0] = 32'd42; b2b_exp[1] = 32'h8000_0000;
      b2b_exp[2] = 32'hF000_0000; b2b_exp[3] = 32'h0000_000F;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            check($sformatf("b2b%0d_result", i - 2), 64'(A_result), 64'(b2b_exp[i-2]));
            check($sformatf("b2b%0d_valid", i - 2), 64'(A_valid), 64'd1);
         end
         case (i)
            0: drive32(MODE_MUL_LO, 32'd6, 32'd7, 1'b0, 1'b0);
            1: drive32(MODE_SHL, 32'd1, 32'd31, 1'b0, 1'b0);
            2: drive32(MODE_ROR, 32'h0000_000F, 32'd4, 1'b0, 1'b0);
            3: drive32(MODE_SHR_L, 32'h0000_00FF, 32'd4, 1'b0, 1'b0);
            default: E_valid = 1'b0;
         endcase
         M_en = (i < 5); A_en = (i < 5);
      end

      // Flush with A_en low is ignored; flush on the A_en edge kills only valid.
      drive32(MODE_ROL, 32'h1234_5678, 32'd4, 1'b0, 1'b0);
      M_en = 1'b1;
      @(negedge clk);
      M_en = 1'b0; M_flush = 1'b1; E_valid = 1'b0;
      @(negedge clk);
      check("flush_noaen_valid", 64'(A_valid), 64'd1);
      check("flush_noaen_result", 64'(A_result), 64'h0000_000F);
      A_en = 1'b1;
      @(negedge clk);
      A_en = 1'b0; M_flush = 1'b0;
      check("flush_result", 64'(A_result), 64'h2345_6781);
      check("flush_valid", 64'(A_valid), 64'd0);
      A_en = 1'b1;
      @(negedge clk);
      A_en = 1'b0;
      check("unflush_valid", 64'(A_valid), 64'd1);

      // Reset between the M_en edge and the A_en edge discards the instruction.
      drive32(MODE_SHL, 32'd3, 32'd2, 1'b0, 1'b0);
      M_en = 1'b1;
      @(negedge clk);
      M_en = 1'b0; E_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      check("midrst_result", 64'(A_result), 64'd0);
      check("midrst_valid", 64'(A_valid), 64'd0);
      #2;
      reset_n = 1'b1;
      A_en = 1'b1;
      @(negedge clk);
      A_en = 1'b0;
      check("postrst_valid", 64'(A_valid), 64'd0);
      check("postrst_result", 64'(A_result), 64'd0);
      run_op(3);

      run8("w8_mulhi_ss", MODE_MUL_HI, 8'h80, 8'h80, 1'b1, 1'b1, 8'h40);
      run8("w8_ror9", MODE_ROR, 8'h01, 8'h09, 1'b0, 1'b0, 8'h80);
      run8("w8_mulhi_uu", MODE_MUL_HI, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE);
      run8("w8_shra", MODE_SHR_A, 8'h90, 8'h0B, 1'b0, 1'b0, 8'hF2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
